// File: rtl/video_pattern_gen.sv
// video_pattern_gen: de/hs/vs test-pattern source (ramps, checker, solid).
// Optional moving ramp: define VIDEO_PATTERN_GEN_FRAME_SHIFT_EN to offset
// the pattern 0/1 ramps by a per-frame counter.
module video_pattern_gen #(
    parameter int unsigned PIXEL_WIDTH = 12,
    parameter int unsigned SPARSE_MAX  = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [15:0]            pix_count,
    input  logic [15:0]            line_count,
    input  logic [3:0]             sparse,
    input  logic [15:0]            hblank,
    input  logic [15:0]            vblank,
    input  logic [1:0]             pattern,
    input  logic [PIXEL_WIDTH-1:0] solid_val,
    output logic [PIXEL_WIDTH-1:0] do_o,
    output logic                   de_o,
    output logic                   hs_o,
    output logic                   vs_o,
    output logic                   busy
);

    localparam int unsigned CNT_W      = 18;
    localparam logic [3:0]  SPARSE_LIM = (SPARSE_MAX > 15) ? 4'd15 : 4'(SPARSE_MAX);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACTIVE = 3'd1,
        GAP    = 3'd2,
        HBLANK = 3'd3,
        VBLANK = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_n;
    logic [15:0]            r_x;
    logic [15:0]            r_y;
    logic [15:0]            w_x_n;
    logic [15:0]            w_y_n;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_n;

    // frame configuration, captured when a frame starts
    logic [15:0]            r_pix;
    logic [15:0]            r_lines;
    logic [3:0]             r_sparse;
    logic [15:0]            r_hblank;
    logic [15:0]            r_vblank;
    logic [1:0]             r_pattern;
    logic [PIXEL_WIDTH-1:0] r_solid;

    logic                   w_start;
    logic                   w_frame_end;
    logic                   w_last_pix;
    logic                   w_last_line;
    logic [CNT_W-1:0]       w_line_wait;
    logic [CNT_W-1:0]       w_frame_wait;

    logic [15:0]            w_pix_in;
    logic [15:0]            w_lines_in;
    logic [3:0]             w_sparse_in;
    logic [1:0]             w_pat;
    logic [PIXEL_WIDTH-1:0] w_solid;
    logic [15:0]            w_ramp_x;
    logic [15:0]            w_ramp_y;
    logic [PIXEL_WIDTH-1:0] w_pix;
    logic                   w_de_n;

`ifdef VIDEO_PATTERN_GEN_FRAME_SHIFT_EN
    logic [15:0]            r_frame;
    logic [15:0]            w_frame_n;
`endif

    // normalise incoming configuration before it is captured
    always_comb begin
        w_pix_in    = (pix_count == 16'd0) ? 16'd1 : pix_count;
        w_lines_in  = (line_count == 16'd0) ? 16'd1 : line_count;
        w_sparse_in = (sparse > SPARSE_LIM) ? SPARSE_LIM : sparse;
    end

    // next-state, coordinate and wait-counter logic
    always_comb begin
        w_state_n    = r_state;
        w_x_n        = r_x;
        w_y_n        = r_y;
        w_cnt_n      = r_cnt;
        w_start      = 1'b0;
        w_frame_end  = 1'b0;
        w_last_pix   = (r_x == (r_pix - 16'd1));
        w_last_line  = (r_y == (r_lines - 16'd1));
        w_line_wait  = CNT_W'(r_sparse) + CNT_W'(r_hblank);
        w_frame_wait = w_line_wait + CNT_W'(r_vblank);

        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_start   = 1'b1;
                    w_state_n = ACTIVE;
                    w_x_n     = 16'd0;
                    w_y_n     = 16'd0;
                end
            end
            ACTIVE: begin
                if (!w_last_pix) begin
                    if (r_sparse != 4'd0) begin
                        w_state_n = GAP;
                        w_cnt_n   = CNT_W'(r_sparse) - CNT_W'(1);
                    end else begin
                        w_x_n = r_x + 16'd1;
                    end
                end else if (!w_last_line) begin
                    if (w_line_wait != '0) begin
                        w_state_n = HBLANK;
                        w_cnt_n   = w_line_wait - CNT_W'(1);
                    end else begin
                        w_x_n = 16'd0;
                        w_y_n = r_y + 16'd1;
                    end
                end else begin
                    if (w_frame_wait != '0) begin
                        w_state_n = VBLANK;
                        w_cnt_n   = w_frame_wait - CNT_W'(1);
                    end else begin
                        w_frame_end = 1'b1;
                    end
                end
            end
            GAP: begin
                if (r_cnt == '0) begin
                    w_state_n = ACTIVE;
                    w_x_n     = r_x + 16'd1;
                end else begin
                    w_cnt_n = r_cnt - CNT_W'(1);
                end
            end
            HBLANK: begin
                if (r_cnt == '0) begin
                    w_state_n = ACTIVE;
                    w_x_n     = 16'd0;
                    w_y_n     = r_y + 16'd1;
                end else begin
                    w_cnt_n = r_cnt - CNT_W'(1);
                end
            end
            VBLANK: begin
                if (r_cnt == '0) begin
                    w_frame_end = 1'b1;
                end else begin
                    w_cnt_n = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase

        // frame end: restart immediately if still enabled, else go idle
        if (w_frame_end) begin
            w_x_n   = 16'd0;
            w_y_n   = 16'd0;
            w_cnt_n = '0;
            if (enable) begin
                w_start   = 1'b1;
                w_state_n = ACTIVE;
            end else begin
                w_state_n = IDLE;
            end
        end
    end

    // pixel value for the coordinate about to be presented
    always_comb begin
        w_pat   = w_start ? pattern   : r_pattern;
        w_solid = w_start ? solid_val : r_solid;
`ifdef VIDEO_PATTERN_GEN_FRAME_SHIFT_EN
        w_frame_n = w_frame_end ? (r_frame + 16'd1) : r_frame;
        w_ramp_x  = w_x_n + w_frame_n;
        w_ramp_y  = w_y_n + w_frame_n;
`else
        w_ramp_x  = w_x_n;
        w_ramp_y  = w_y_n;
`endif
        case (w_pat)
            2'd0:    w_pix = PIXEL_WIDTH'(w_ramp_x);
            2'd1:    w_pix = PIXEL_WIDTH'(w_ramp_y);
            2'd2:    w_pix = (w_x_n[3] ^ w_y_n[3]) ? {PIXEL_WIDTH{1'b1}} : '0;
            default: w_pix = w_solid;
        endcase
        w_de_n = (w_state_n == ACTIVE);
    end

    // state, counters, captured configuration and aligned output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_x       <= 16'd0;
            r_y       <= 16'd0;
            r_cnt     <= '0;
            r_pix     <= 16'd1;
            r_lines   <= 16'd1;
            r_sparse  <= 4'd0;
            r_hblank  <= 16'd0;
            r_vblank  <= 16'd0;
            r_pattern <= 2'd0;
            r_solid   <= '0;
            do_o      <= '0;
            de_o      <= 1'b0;
            hs_o      <= 1'b0;
            vs_o      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_x     <= w_x_n;
            r_y     <= w_y_n;
            r_cnt   <= w_cnt_n;
            if (w_start) begin
                r_pix     <= w_pix_in;
                r_lines   <= w_lines_in;
                r_sparse  <= w_sparse_in;
                r_hblank  <= hblank;
                r_vblank  <= vblank;
                r_pattern <= pattern;
                r_solid   <= solid_val;
            end
            do_o <= w_de_n ? w_pix : '0;
            de_o <= w_de_n;
            hs_o <= w_de_n && (w_x_n == 16'd0);
            vs_o <= w_de_n && (w_x_n == 16'd0) && (w_y_n == 16'd0);
            busy <= (w_state_n != IDLE);
        end
    end

`ifdef VIDEO_PATTERN_GEN_FRAME_SHIFT_EN
    // frame counter driving the moving ramp
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame <= 16'd0;
        end else begin
            r_frame <= w_frame_n;
        end
    end
`endif

endmodule
